alu_beat_ctrl: RTL
==================

# alu_beat_ctrl

Instruction sequencer that sits directly upstream of the 8-bit ALU. It accepts one instruction byte over a ready/start handshake and decodes the opcode into the ALU's one-hot operation flags. It generates the one-hot 8-beat timing bus `T[7:0]` that the multiply and divide units sample, and it drives the register-file read selects, write selects and write strobes that capture the ALU output, including the two-result writeback for MUL and DIV.

## Interface
Parameters: none (datapath width fixed at 8, beat count fixed at 8).
- `clk` in 1 — single clock; all state changes on rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `start` in 1 — instruction valid; accepted only when `ready`=1.
- `instr` in 8 — `[7:4]` opcode, `[3:2]` dst reg, `[1:0]` src reg (0=AX,1=BX,2=CX,3=DX).
- `stall` in 1 — freezes the beat sequence while high.
- `ready` out 1 — sequencer idle, can accept `start`.
- `done` out 1 — one-cycle pulse at instruction completion.
- `err` out 1 — one-cycle pulse with `done` for an illegal opcode.
- `T` out 8 — one-hot beat bus to the ALU; 0 when idle.
- `IMOV,IADD,ISUB,IMUL,IDIV,IOR,INOT,IAND,IXOR,ISHL,ISHR` out 1 each — one-hot ALU op flags.
- `EALU` out 1 — ALU output enable.
- `rd_a_sel` out 2 — register onto ALU port A.
- `rd_b_sel` out 2 — register onto ALU port B.
- `wr_sel` out 2 — register written from ALU `OUT`.
- `wr_en` out 1 — register write strobe.

## Operation
- Opcodes: 0 MOV, 1 ADD, 2 SUB, 3 MUL, 4 DIV, 5 OR, 6 NOT, 7 AND, 8 XOR, 9 SHL, A SHR. B–F are illegal.
- States: IDLE, RUN (beats T0..T7), DONE.
  - IDLE→RUN on `start`&`ready`; `instr` is latched at this edge.
  - RUN advances one beat per unstalled cycle.
  - After T7, RUN→DONE. DONE lasts one cycle, then goes to IDLE.
- `ready`=1 in IDLE and DONE. `start` in DONE is accepted, so T0 follows immediately (back-to-back operation).
- `start` while in RUN is ignored; the latched instruction is unaffected.
- Op flag: exactly one flag, selected by the latched opcode, is high for all of RUN (T0..T7). All flags are 0 in IDLE and DONE. An illegal opcode yields no flag.
- `rd_a_sel`=dst and `rd_b_sel`=src, held for all of RUN. Both are 0 otherwise.
- Writeback for single-result ops:
  - `EALU`=1, `wr_en`=1, `wr_sel`=dst during T6 only.
- Writeback for MUL/DIV:
  - `EALU`=1 during T6 and T7.
  - T6: `wr_sel`=0 (AX, low product / quotient).
  - T7: `wr_sel`=3 (DX, high product / remainder).
  - The dst field is ignored for writeback.
- `wr_en` is gated by `!stall`, giving exactly one strobe per write beat regardless of stall length.
- Illegal opcode: the full 8-beat sequence runs with no flags, `EALU`=0 and `wr_en`=0. `err`=1 together with `done`.
- `stall` (in RUN): `T`, the flags and the selects hold their values; only `wr_en` is suppressed. `stall` has no effect in IDLE or DONE.

## Timing
- Reset values: state IDLE, `T`=0, all flags 0, `EALU`=0, `wr_en`=0, selects 0, `done`=0, `err`=0, `ready`=1. The latched instruction is 0.
- With accept at edge n (no stall):
  - T0 visible in cycle n+1 … T7 in cycle n+8.
  - `done` in cycle n+9.
  - Total: 9 cycles per instruction; the next accept is at edge n+9.
- Each stall cycle adds one cycle of latency.
- `T` is strictly one-hot during RUN. There is no glitch between beats, because `T` is registered.
  - The T3→T4 transition gives the divider its T3 falling edge.
  - T5 rising gives its compute edge.
  - T6 high selects the low/quotient result.
- `rst` in any state (including mid-RUN or stalled): the next edge returns all outputs to reset values. No `wr_en` or `done` is emitted for the aborted instruction.
- `rst` together with `start`: reset wins, and the instruction is not accepted.

## Test plan
- ADD BX,CX (`instr`=8'h16), start at cycle 0:
  - `IADD`=1 for cycles 1–8, `T` walks 01→80.
  - `wr_en`=1, `wr_sel`=1 only in cycle 7.
  - `done`=1 in cycle 9, `err`=0.
- MUL AX,BX (`instr`=8'h31):
  - `wr_en` in cycles 7 (`wr_sel`=0) and 8 (`wr_sel`=3).
  - `EALU`=1 in cycles 7–8.
  - With AX=8'h10, BX=8'h20 through the ALU, the bench sees AX=8'h00 and DX=8'h02.
- DIV with `stall` high for 3 cycles during T6:
  - `T` holds 8'h40 for 4 cycles.
  - Exactly one `wr_en` to AX, then one to DX.
  - `done` in cycle 12.
- Illegal opcode 8'hF5:
  - 8 beats run with no flags and no `wr_en`.
  - `done`=`err`=1 in cycle 9.
- Back-to-back: second `start` in the `done` cycle (cycle 9) produces T0 in cycle 10. A `start` pulse in cycle 4 is ignored.
- `rst` asserted in cycle 5 of a SUB:
  - `T`=0 and `ready`=1 from cycle 6.
  - No `wr_en` or `done` for the SUB.
  - A new instruction after reset completes normally.

Source files
------------

// File: rtl/alu_beat_ctrl_if.sv
// Handshake and control bus between the instruction source, the beat sequencer
// and the ALU / register file it steers.
interface alu_beat_ctrl_if;
  logic       start;
  logic [7:0] instr;
  logic       stall;
  logic       ready;
  logic       done;
  logic       err;
  logic [7:0] T;
  logic       IMOV, IADD, ISUB, IMUL, IDIV, IOR, INOT, IAND, IXOR, ISHL, ISHR;
  logic       EALU;
  logic [1:0] rd_a_sel;
  logic [1:0] rd_b_sel;
  logic [1:0] wr_sel;
  logic       wr_en;

  modport master (
    output start, instr, stall,
    input  ready, done, err, T,
    input  IMOV, IADD, ISUB, IMUL, IDIV, IOR, INOT, IAND, IXOR, ISHL, ISHR,
    input  EALU, rd_a_sel, rd_b_sel, wr_sel, wr_en
  );

  modport slave (
    input  start, instr, stall,
    output ready, done, err, T,
    output IMOV, IADD, ISUB, IMUL, IDIV, IOR, INOT, IAND, IXOR, ISHL, ISHR,
    output EALU, rd_a_sel, rd_b_sel, wr_sel, wr_en
  );
endinterface

// File: rtl/alu_beat_ctrl.sv
// Eight-beat instruction sequencer for the 8-bit ALU: latches one instruction,
// walks a registered one-hot beat bus and strobes the result writeback(s).
module alu_beat_ctrl (
  input  logic            clk,
  input  logic            rst,
  alu_beat_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  typedef struct packed {
    logic [3:0] op;
    logic [1:0] dst;
    logic [1:0] src;
  } instr_t;

  localparam logic [3:0] OP_MUL  = 4'h3;
  localparam logic [3:0] OP_DIV  = 4'h4;
  localparam logic [3:0] OP_LAST = 4'hA;

  state_t      state, state_nxt;
  logic [7:0]  beat, beat_nxt;
  instr_t      ir, ir_nxt;

  logic        run, legal, muldiv, wb_beat;
  logic [10:0] opf;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      beat  <= '0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
      ir    <= ir_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    ir_nxt    = ir;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt = S_RUN;
          beat_nxt  = 8'h01;
          ir_nxt    = bus.instr;
        end
      end
      S_RUN: begin
        // stall freezes the beat; start is ignored until the sequence ends
        if (!bus.stall) begin
          if (beat[7]) begin
            state_nxt = S_DONE;
            beat_nxt  = '0;
          end else begin
            beat_nxt = beat << 1;
          end
        end
      end
      S_DONE: begin
        if (bus.start) begin
          state_nxt = S_RUN;
          beat_nxt  = 8'h01;
          ir_nxt    = bus.instr;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        beat_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    run     = (state == S_RUN);
    legal   = (ir.op <= OP_LAST);
    muldiv  = (ir.op == OP_MUL) || (ir.op == OP_DIV);
    opf     = (run && legal) ? (11'(1) << ir.op) : '0;
    // MUL/DIV write two results (T6 low/quotient, T7 high/remainder)
    wb_beat = run && legal && (muldiv ? (beat[6] | beat[7]) : beat[6]);

    bus.ready    = !run;
    bus.done     = (state == S_DONE);
    bus.err      = (state == S_DONE) && !legal;
    bus.T        = beat;
    bus.IMOV     = opf[0];
    bus.IADD     = opf[1];
    bus.ISUB     = opf[2];
    bus.IMUL     = opf[3];
    bus.IDIV     = opf[4];
    bus.IOR      = opf[5];
    bus.INOT     = opf[6];
    bus.IAND     = opf[7];
    bus.IXOR     = opf[8];
    bus.ISHL     = opf[9];
    bus.ISHR     = opf[10];
    bus.EALU     = wb_beat;
    bus.wr_en    = wb_beat && !bus.stall;
    bus.rd_a_sel = run ? ir.dst : 2'd0;
    bus.rd_b_sel = run ? ir.src : 2'd0;
    bus.wr_sel   = 2'd0;
    if (wb_beat) bus.wr_sel = muldiv ? (beat[7] ? 2'd3 : 2'd0) : ir.dst;
  end
endmodule
